// File: rtl/typ_store_writer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// typ_store_writer_if : request, memory-write and completion bundle of the
// typed store writer.   Revision: 1.0
// ---------------------------------------------------------------------------
interface typ_store_writer_if #(
  parameter int XLEN      = 32,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 32,
  parameter int TAG_W     = 8
);
  logic                      io_in_valid;
  logic                      io_in_ready;
  logic [ADDR_W-1:0]         io_in_addr;
  logic [NUM_WORDS*XLEN-1:0] io_in_data;
  logic [TAG_W-1:0]          io_in_tag;

  logic                      io_mem_req_valid;
  logic                      io_mem_req_ready;
  logic [ADDR_W-1:0]         io_mem_req_addr;
  logic [XLEN-1:0]           io_mem_req_data;
  logic                      io_mem_resp_valid;

  logic                      io_out_valid;
  logic                      io_out_ready;
  logic [TAG_W-1:0]          io_out_tag;

  modport slave (
    input  io_in_valid, io_in_addr, io_in_data, io_in_tag,
    output io_in_ready,
    output io_mem_req_valid, io_mem_req_addr, io_mem_req_data,
    input  io_mem_req_ready, io_mem_resp_valid,
    output io_out_valid, io_out_tag,
    input  io_out_ready
  );

  modport master (
    output io_in_valid, io_in_addr, io_in_data, io_in_tag,
    input  io_in_ready,
    input  io_mem_req_valid, io_mem_req_addr, io_mem_req_data,
    output io_mem_req_ready, io_mem_resp_valid,
    input  io_out_valid, io_out_tag,
    output io_out_ready
  );
endinterface
`default_nettype wire

// File: rtl/typ_store_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// typ_store_writer : serializes a typed aggregate into word writes and reports
// completion once every write is acknowledged.   Revision: 1.0
// ---------------------------------------------------------------------------
module typ_store_writer #(
  parameter int XLEN      = 32,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 32,
  parameter int TAG_W     = 8
) (
  input wire                 clock,
  input wire                 reset,
  typ_store_writer_if.slave  io_bus
);
  localparam int c_CNT_W = $clog2(NUM_WORDS + 1);
  localparam int c_SEL_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int c_BYTES = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    r_state;
  logic [ADDR_W-1:0]         r_addr;
  logic [NUM_WORDS*XLEN-1:0] r_data;
  logic [TAG_W-1:0]          r_tag;
  logic [c_CNT_W-1:0]        r_sent;
  logic [c_CNT_W-1:0]        r_acked;
  logic                      r_in_ready;
  logic                      r_req_valid;
  logic                      r_out_valid;

  logic                      w_req_hs;
  logic                      w_last;
  logic                      w_ack;
  logic [c_CNT_W-1:0]        w_acked_next;
  logic [c_SEL_W-1:0]        w_sel;
  logic [XLEN-1:0]           w_elem [NUM_WORDS];

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_elem
    assign w_elem[gi] = r_data[gi*XLEN +: XLEN];
  end

  assign w_req_hs     = r_req_valid & io_bus.io_mem_req_ready;
  assign w_last       = (r_sent == c_CNT_W'(NUM_WORDS - 1));
  // Acks only count against words already issued (registered count).
  assign w_ack        = io_bus.io_mem_resp_valid
                      & ((r_state == S_SEND) | (r_state == S_WAIT))
                      & (r_acked < r_sent);
  assign w_acked_next = r_acked + {{(c_CNT_W-1){1'b0}}, w_ack};
  assign w_sel        = r_sent[c_SEL_W-1:0];

  assign io_bus.io_in_ready      = r_in_ready;
  assign io_bus.io_mem_req_valid = r_req_valid;
  assign io_bus.io_mem_req_addr  = r_addr + ADDR_W'(r_sent) * ADDR_W'(c_BYTES);
  assign io_bus.io_mem_req_data  = w_elem[w_sel];
  assign io_bus.io_out_valid     = r_out_valid;
  assign io_bus.io_out_tag       = r_tag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_tag       <= '0;
      r_sent      <= '0;
      r_acked     <= '0;
      r_in_ready  <= 1'b1;
      r_req_valid <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.io_in_valid && r_in_ready) begin
            r_addr      <= io_bus.io_in_addr;
            r_data      <= io_bus.io_in_data;
            r_tag       <= io_bus.io_in_tag;
            r_sent      <= '0;
            r_acked     <= '0;
            r_in_ready  <= 1'b0;
            r_req_valid <= 1'b1;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          r_acked <= w_acked_next;
          if (w_req_hs) begin
            r_sent <= r_sent + c_CNT_W'(1);
            if (w_last) begin
              r_req_valid <= 1'b0;
              r_state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_acked <= w_acked_next;
          if (w_acked_next == c_CNT_W'(NUM_WORDS)) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (io_bus.io_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_req_valid <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: doc/typ_store_writer.md
Name: typ_store_writer

Overview:
- Write-side counterpart of the typed-load/compute path in the typed-memory dataflow.
- Accepts one typed aggregate, e.g. a 2x2 Vec(Vec(UInt32)) result from the typed compute unit, as a single flat word bundle plus base address.
- Serializes it into word-sized memory write requests and counts write acknowledgements.
- Signals completion with the request tag once all words are acknowledged.

Parameters:
- XLEN, 32, width of one memory word / one typed element in bits.
- NUM_WORDS, 4, elements per typed aggregate (2x2 matrix = 4).
- ADDR_W, 32, memory address width.
- TAG_W, 8, width of the request tag passed through to completion.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- io_in_valid  in  1  typed store request valid.
- io_in_ready  out  1  writer can accept a request.
- io_in_addr  in  ADDR_W  byte base address of element 0.
- io_in_data  in  NUM_WORDS*XLEN  flattened aggregate; element i = bits [(i+1)*XLEN-1 : i*XLEN].
- io_in_tag  in  TAG_W  request identifier.
- io_mem_req_valid  out  1  word write request valid.
- io_mem_req_ready  in  1  memory accepts the request.
- io_mem_req_addr  out  ADDR_W  word write byte address.
- io_mem_req_data  out  XLEN  word write data.
- io_mem_resp_valid  in  1  one write acknowledgement, single-cycle pulse, in order.
- io_out_valid  out  1  aggregate store complete.
- io_out_ready  in  1  consumer takes the completion.
- io_out_tag  out  TAG_W  tag of the completed store.

Behaviour:
- Reset values: state=IDLE, io_in_ready=1 after reset deasserts, io_mem_req_valid=0, io_out_valid=0, io_out_tag=0. Internal addr/data/tag registers are 0; sent and acked counters are 0.
- Counter width: clog2(NUM_WORDS+1).

IDLE:
- io_in_ready=1. No other state asserts io_in_ready.
- On io_in_valid & io_in_ready: latch addr, data and tag; clear sent and acked; go to SEND.

SEND:
- io_mem_req_valid=1.
- io_mem_req_addr = latched_addr + sent*(XLEN/8), truncated mod 2^ADDR_W; wrap-around is silent.
- io_mem_req_data = element[sent].
- A handshake is io_mem_req_valid & io_mem_req_ready. On a handshake, sent increments. If the handshake is for element NUM_WORDS-1, go to WAIT.
- Request addr/data stay stable while valid and not ready.

Acks (SEND and WAIT):
- io_mem_resp_valid increments acked only while acked < sent, using the registered sent value.
- An ack in the same cycle as a req handshake is counted. Acks beyond sent are ignored. Acks in IDLE or DONE are ignored.

WAIT:
- io_mem_req_valid=0.
- When acked reaches NUM_WORDS, including an ack arriving this cycle, go to DONE on the next edge.

DONE:
- io_out_valid=1, io_out_tag=latched tag.
- On io_out_ready: go to IDLE. A new request is accepted no earlier than the following cycle.

Latency and timing:
- Minimum latency, request accept to io_out_valid: NUM_WORDS+2 cycles. This assumes req_ready is held 1 and each ack arrives the cycle after its request.
- Requests are pipelined: up to NUM_WORDS writes may be outstanding.

Reset mid-operation: returns to IDLE immediately. The in-flight aggregate is discarded and no completion is produced. Late acks after reset are ignored.

Test Plan:
- Basic store: addr=0x1000, data elements {0x11,0x22,0x33,0x44}, tag=0x5A, req_ready=1, acks 1 cycle later -> writes (0x1000,0x11),(0x1004,0x22),(0x1008,0x33),(0x100C,0x44) in consecutive cycles; out_valid with tag 0x5A at accept+6 cycles.
- Backpressure: req_ready=0 for 3 cycles on element 2 -> addr 0x1008/data 0x33 held stable, no duplicate write, exactly 4 writes total.
- Wrap-around: addr=0xFFFFFFF8 -> write addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Simultaneous ack + request and delayed acks: all 4 acks arrive 5 cycles after the last request -> out_valid only after the 4th ack. A spurious ack while in IDLE does not advance state.
- Completion stall: out_ready=0 for 4 cycles -> out_valid and tag held, in_ready=0. After the out_ready handshake, a second store is accepted and completes with its own tag.
- Async reset mid-store after 2 words sent -> req_valid and out_valid drop to 0 immediately. After deassert, in_ready=1 and no completion for the aborted tag.
